// File: rtl/wb_hazard_ctrl.sv
// Writeback-stage hazard controller: memory-wait stalls with timeout, taken-branch flush,
// registered writeback select/destination and writeback-to-execute forwarding.
module wb_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid_ex,
  input  logic [1:0] i_wb_sel_ex,
  input  logic       i_reg_wr_ex,
  input  logic       i_mem_wr_ex,
  input  logic [4:0] i_rd_ex,
  input  logic [4:0] i_rs1_ex,
  input  logic [4:0] i_rs2_ex,
  input  logic       i_br_taken_ex,
  input  logic       i_dmem_ack,
  output logic       o_dmem_req,
  output logic       o_stall,
  output logic       o_flush,
  output logic [1:0] o_wb_sel,
  output logic       o_reg_wr,
  output logic [4:0] o_rd,
  output logic       o_fwd_a,
  output logic       o_fwd_b,
  output logic       o_dmem_err
);

  localparam logic [1:0] J_WB    = 2'd0;
  localparam logic [1:0] ALU_WB  = 2'd1;
  localparam logic [1:0] DMEM_WB = 2'd2;
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {RUN = 2'd0, WAIT_MEM = 2'd1, FLUSH = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          mem_op, advance, timeout, stall_int, flush_int, req_int;

  // Next-state, wait counter and per-cycle pipeline control.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_int = 1'b0;
    flush_int = 1'b0;
    req_int   = 1'b0;
    advance   = 1'b0;
    timeout   = 1'b0;
    mem_op    = i_valid_ex & ((i_wb_sel_ex == DMEM_WB) | i_mem_wr_ex);
    case (state)
      RUN: begin
        req_int   = mem_op;
        stall_int = mem_op & ~i_dmem_ack;
        advance   = i_valid_ex & ~stall_int;
        if (stall_int) begin
          state_nxt = WAIT_MEM;
        end else if (advance & i_br_taken_ex) begin
          flush_int = 1'b1;
          state_nxt = FLUSH;
        end else begin
          state_nxt = RUN;
        end
      end
      WAIT_MEM: begin
        req_int   = 1'b1;
        stall_int = 1'b1;
        // Ack beats a simultaneous timeout; the last waiting cycle is MAX_WAIT-th.
        if (i_dmem_ack) begin
          advance   = 1'b1;
          cnt_nxt   = {CW{1'b0}};
          state_nxt = RUN;
        end else if (cnt == CW'(MAX_WAIT - 1)) begin
          timeout   = 1'b1;
          cnt_nxt   = {CW{1'b0}};
          state_nxt = RUN;
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
      end
      FLUSH: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter and registered writeback controls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= RUN;
      cnt        <= {CW{1'b0}};
      o_wb_sel   <= ALU_WB;
      o_rd       <= 5'd0;
      o_reg_wr   <= 1'b0;
      o_dmem_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      o_dmem_err <= timeout;
      if (advance) begin
        o_wb_sel <= i_wb_sel_ex;
        o_rd     <= i_rd_ex;
        o_reg_wr <= i_reg_wr_ex & ~i_mem_wr_ex & (i_rd_ex != 5'd0);
      end else if (timeout | ~stall_int) begin
        o_reg_wr <= 1'b0;
      end else begin
        o_reg_wr <= o_reg_wr;
      end
    end
  end

  assign o_dmem_req = req_int & ~i_rst;
  assign o_stall    = stall_int & ~i_rst;
  assign o_flush    = flush_int & ~i_rst;
  assign o_fwd_a    = o_reg_wr & (o_rd != 5'd0) & (o_rd == i_rs1_ex) & ~i_rst;
  assign o_fwd_b    = o_reg_wr & (o_rd != 5'd0) & (o_rd == i_rs2_ex) & ~i_rst;

endmodule

// File: tb/tb_wb_hazard_ctrl.sv
// Directed self-checking bench for wb_hazard_ctrl: ALU forwarding, delayed load, timeout,
// ack-at-timeout, store, taken jump flush and reset in the middle of a memory wait.
module tb_wb_hazard_ctrl;
  localparam logic [1:0] J_WB    = 2'd0;
  localparam logic [1:0] ALU_WB  = 2'd1;
  localparam logic [1:0] DMEM_WB = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, reg_wr_ex, mem_wr_ex, br, ack;
  logic [1:0] sel_ex;
  logic [4:0] rd_ex, rs1, rs2;
  logic       dmem_req, stall, flush, reg_wr, fwd_a, fwd_b, dmem_err;
  logic [1:0] wb_sel;
  logic [4:0] rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_hazard_ctrl #(.MAX_WAIT(15)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid_ex(valid), .i_wb_sel_ex(sel_ex),
    .i_reg_wr_ex(reg_wr_ex), .i_mem_wr_ex(mem_wr_ex), .i_rd_ex(rd_ex),
    .i_rs1_ex(rs1), .i_rs2_ex(rs2), .i_br_taken_ex(br), .i_dmem_ack(ack),
    .o_dmem_req(dmem_req), .o_stall(stall), .o_flush(flush), .o_wb_sel(wb_sel),
    .o_reg_wr(reg_wr), .o_rd(rd), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
    .o_dmem_err(dmem_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs are applied 1 ns after a rising edge and checked 1 ns later.
  task automatic set_in(input logic v, input logic [1:0] s, input logic w, input logic m,
                        input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                        input logic t, input logic k);
    valid = v; sel_ex = s; reg_wr_ex = w; mem_wr_ex = m;
    rd_ex = d; rs1 = a; rs2 = b; br = t; ack = k;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_in(1'b1, DMEM_WB, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    #2;
    check("rst_req", dmem_req, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_wb_sel", wb_sel, ALU_WB);
    check("rst_rd", rd, 5'd0);
    check("rst_reg_wr", reg_wr, 1'b0);
    check("rst_err", dmem_err, 1'b0);
    check("rst_fwd_a", fwd_a, 1'b0);
    tick; tick;
    rst = 1'b0;
    set_in(1'b0, ALU_WB, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick;

    // ALU add rd=5, then a consumer of x5 on rs1.
    set_in(1'b1, ALU_WB, 1'b1, 1'b0, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0);
    #1;
    check("alu_stall", stall, 1'b0);
    check("alu_req", dmem_req, 1'b0);
    tick;
    set_in(1'b1, ALU_WB, 1'b1, 1'b0, 5'd6, 5'd5, 5'd3, 1'b0, 1'b0);
    #1;
    check("alu_reg_wr", reg_wr, 1'b1);
    check("alu_rd", rd, 5'd5);
    check("alu_sel", wb_sel, ALU_WB);
    check("alu_fwd_a", fwd_a, 1'b1);
    check("alu_fwd_b", fwd_b, 1'b0);

    // rd=0 with write enable must not write or forward.
    tick;
    set_in(1'b1, ALU_WB, 1'b1, 1'b0, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0);
    #1;
    check("x6_fwd_b", fwd_b, 1'b1);
    tick;
    set_in(1'b0, ALU_WB, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("x0_reg_wr", reg_wr, 1'b0);
    check("x0_fwd_a", fwd_a, 1'b0);
    tick;
    check("bubble_reg_wr", reg_wr, 1'b0);

    // Load rd=7, ack in the 4th request cycle.
    set_in(1'b1, DMEM_WB, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ack = 1'b1;
      #1;
      check("ld_stall", stall, 1'b1);
      check("ld_req", dmem_req, 1'b1);
      check("ld_hold_reg_wr", reg_wr, 1'b0);
      tick;
    end
    set_in(1'b0, ALU_WB, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("ld_reg_wr", reg_wr, 1'b1);
    check("ld_rd", rd, 5'd7);
    check("ld_sel", wb_sel, DMEM_WB);
    check("ld_stall_done", stall, 1'b0);

    // Store with immediate ack never writes the register file.
    tick;
    set_in(1'b1, ALU_WB, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b1);
    #1;
    check("st_req", dmem_req, 1'b1);
    check("st_stall", stall, 1'b0);
    tick;
    set_in(1'b0, ALU_WB, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("st_reg_wr", reg_wr, 1'b0);
    check("st_rd", rd, 5'd9);

    // Load rd=8 with no ack: entry cycle + 15 waiting cycles, then error pulse.
    tick;
    set_in(1'b1, DMEM_WB, 1'b1, 1'b0, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      #1;
      check("to_stall", stall, 1'b1);
      check("to_err_low", dmem_err, 1'b0);
      tick;
    end
    set_in(1'b0, ALU_WB, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("to_err", dmem_err, 1'b1);
    check("to_stall_done", stall, 1'b0);
    check("to_req", dmem_req, 1'b0);
    check("to_reg_wr", reg_wr, 1'b0);
    check("to_rd_hold", rd, 5'd9);
    tick;
    check("to_err_pulse", dmem_err, 1'b0);

    // Ack in the last waiting cycle wins over the timeout.
    set_in(1'b1, DMEM_WB, 1'b1, 1'b0, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) ack = 1'b1;
      tick;
    end
    set_in(1'b0, ALU_WB, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("race_err", dmem_err, 1'b0);
    check("race_reg_wr", reg_wr, 1'b1);
    check("race_rd", rd, 5'd10);

    // Taken branch without a valid instruction is ignored.
    tick;
    set_in(1'b0, J_WB, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0);
    #1;
    check("br_novalid_flush", flush, 1'b0);

    // JAL rd=1 taken: flush, next instruction (a load) is bubbled.
    tick;
    set_in(1'b1, J_WB, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0);
    #1;
    check("jal_flush", flush, 1'b1);
    check("jal_stall", stall, 1'b0);
    tick;
    set_in(1'b1, DMEM_WB, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("jal_flush_once", flush, 1'b0);
    check("flush_req", dmem_req, 1'b0);
    check("flush_stall", stall, 1'b0);
    check("jal_reg_wr", reg_wr, 1'b1);
    check("jal_rd", rd, 5'd1);
    check("jal_sel", wb_sel, J_WB);
    tick;
    set_in(1'b0, ALU_WB, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("bubbled_reg_wr", reg_wr, 1'b0);
    check("bubbled_rd", rd, 5'd1);

    // Reset in the second waiting cycle of a load, then a late ack.
    tick;
    set_in(1'b1, DMEM_WB, 1'b1, 1'b0, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0);
    tick; tick;
    rst = 1'b1;
    #1;
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_req", dmem_req, 1'b0);
    check("mid_rst_rd", rd, 5'd0);
    check("mid_rst_sel", wb_sel, ALU_WB);
    tick;
    rst = 1'b0;
    set_in(1'b0, ALU_WB, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    #1;
    check("late_ack_stall", stall, 1'b0);
    check("late_ack_req", dmem_req, 1'b0);
    tick;
    check("late_ack_reg_wr", reg_wr, 1'b0);
    check("late_ack_rd", rd, 5'd0);
    check("late_ack_err", dmem_err, 1'b0);
    check("late_ack_sel", wb_sel, ALU_WB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
